// File: rtl/cpu_fetch_unit_if.sv
// Fetch-unit bus bundle: shared memory port plus the execute-stage side.
// master = fetch unit, slave = memory/execute environment.
interface cpu_fetch_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
) ();
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              mem_ready;
    logic [DATA_W-1:0] ins;
    logic              ins_valid;
    logic              ins_ack;
    logic              branch_en;
    logic              branch_rel;
    logic [ADDR_W-1:0] branch_target;
    logic              halt;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic [ADDR_W-1:0] pc;
    logic              halted;

    modport master (
        output mem_cmd, mem_addr, write_data,
        output ins, ins_valid, d_rdata, d_done, pc, halted,
        input  read_data, mem_ready, ins_ack,
        input  branch_en, branch_rel, branch_target, halt,
        input  d_req, d_we, d_addr, d_wdata
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data,
        input  ins, ins_valid, d_rdata, d_done, pc, halted,
        output read_data, mem_ready, ins_ack,
        output branch_en, branch_rel, branch_target, halt,
        output d_req, d_we, d_addr, d_wdata
    );
endinterface

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch and shared memory-port controller for the 16-bit CPU.
// Owns PC/IR and arbitrates the one memory port between fetch and load/store.
module cpu_fetch_unit #(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 9,
    parameter int unsigned RESET_PC = 0
) (
    input  logic           clk,
    input  logic           reset,
    cpu_fetch_unit_if.master bus
);
    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DATA,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ins_q, ins_d;
    logic              vld_q, vld_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RST_PC;
            ins_q   <= '0;
            vld_q   <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            daddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            vld_q   <= vld_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            we_q    <= we_d;
            daddr_q <= daddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state, datapath updates and memory-port decode.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        vld_d   = vld_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        we_d    = we_q;
        daddr_d = daddr_q;
        wdata_d = wdata_q;
        cmd     = MNONE;
        addr    = pc_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                cmd = MREAD;
                if (bus.mem_ready) begin
                    ins_d   = bus.read_data;
                    pc_d    = pc_q + ADDR_W'(1);
                    vld_d   = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // Data requests win; a concurrent ack is dropped.
                if (bus.d_req) begin
                    we_d    = bus.d_we;
                    daddr_d = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    state_d = S_DATA;
                end else if (bus.ins_ack) begin
                    vld_d = 1'b0;
                    if (bus.halt) begin
                        state_d = S_HALT;
                    end else begin
                        if (bus.branch_en) begin
                            pc_d = bus.branch_rel
                                 ? pc_q + bus.branch_target
                                 : bus.branch_target;
                        end
                        state_d = S_FETCH;
                    end
                end
            end
            S_DATA: begin
                cmd  = we_q ? MWRITE : MREAD;
                addr = daddr_q;
                if (bus.mem_ready) begin
                    if (!we_q) begin
                        rdata_d = bus.read_data;
                    end
                    done_d  = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.mem_cmd    = cmd;
    assign bus.mem_addr   = addr;
    assign bus.write_data = wdata_q;
    assign bus.ins        = ins_q;
    assign bus.ins_valid  = vld_q;
    assign bus.d_rdata    = rdata_q;
    assign bus.d_done     = done_q;
    assign bus.pc         = pc_q;
    assign bus.halted     = (state_q == S_HALT);
endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Bench for cpu_fetch_unit: directed plan steps with literal expectations,
// then random traffic checked each cycle against a transaction-level model.
module tb_cpu_fetch_unit;
    localparam int DW    = 16;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cpu_fetch_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    cpu_fetch_unit #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .RESET_PC(0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [DW-1:0] mem [DEPTH];
    assign bus.read_data = mem[bus.mem_addr];

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 0;

    // Model: what the unit is busy with, expressed as activity flags.
    bit            m_started, m_fetching, m_have, m_data, m_stopped;
    bit            m_we, m_done;
    int            m_pc, m_daddr;
    logic [DW-1:0] m_ins, m_wdata, m_drdata;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_started  = 0;
        m_fetching = 0;
        m_have     = 0;
        m_data     = 0;
        m_stopped  = 0;
        m_we       = 0;
        m_done     = 0;
        m_pc       = 0;
        m_daddr    = 0;
        m_ins      = '0;
        m_wdata    = '0;
        m_drdata   = '0;
    endfunction

    // Model advance: one clock of the fetch/data/halt rules.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_reset();
        end else begin
            m_done = 0;
            if (!m_started) begin
                m_started  = 1;
                m_fetching = 1;
            end else if (m_stopped) begin
                m_stopped = 1;
            end else if (m_fetching) begin
                if (bus.mem_ready) begin
                    m_ins      = mem[m_pc];
                    m_pc       = (m_pc + 1) % DEPTH;
                    m_fetching = 0;
                    m_have     = 1;
                end
            end else if (m_data) begin
                if (bus.mem_ready) begin
                    if (m_we) mem[m_daddr] = m_wdata;
                    else      m_drdata = mem[m_daddr];
                    m_done = 1;
                    m_data = 0;
                end
            end else if (bus.d_req) begin
                m_data  = 1;
                m_we    = bus.d_we;
                m_daddr = int'(bus.d_addr);
                m_wdata = bus.d_wdata;
            end else if (bus.ins_ack) begin
                m_have = 0;
                if (bus.halt) begin
                    m_stopped = 1;
                end else begin
                    if (bus.branch_en) begin
                        if (bus.branch_rel)
                            m_pc = (m_pc + int'(bus.branch_target)) % DEPTH;
                        else
                            m_pc = int'(bus.branch_target);
                    end
                    m_fetching = 1;
                end
            end
        end
    end

    function automatic int exp_cmd();
        if (m_data)     return m_we ? 2 : 1;
        if (m_fetching) return 1;
        return 0;
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            chk("mem_cmd", 32'(bus.mem_cmd), 32'(exp_cmd()));
            if (exp_cmd() != 0 || m_have)
                chk("mem_addr", 32'(bus.mem_addr),
                    32'(m_data ? m_daddr : m_pc));
            chk("pc", 32'(bus.pc), 32'(m_pc));
            chk("ins", 32'(bus.ins), 32'(m_ins));
            chk("ins_valid", 32'(bus.ins_valid), 32'(m_have));
            chk("write_data", 32'(bus.write_data), 32'(m_wdata));
            chk("d_rdata", 32'(bus.d_rdata), 32'(m_drdata));
            chk("d_done", 32'(bus.d_done), 32'(m_done));
            chk("halted", 32'(bus.halted), 32'(m_stopped));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.mem_ready     = 0;
        bus.ins_ack       = 0;
        bus.branch_en     = 0;
        bus.branch_rel    = 0;
        bus.branch_target = '0;
        bus.halt          = 0;
        bus.d_req         = 0;
        bus.d_we          = 0;
        bus.d_addr        = '0;
        bus.d_wdata       = '0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        mem[0] = 16'hA5A5;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        reset  = 0;
        cmp_en = 1;

        // Plan 1: two wait states, three MREAD cycles at address 0.
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("p1_cmd", 32'(bus.mem_cmd), 32'd1);
            chk("p1_addr", 32'(bus.mem_addr), 32'd0);
        end
        bus.mem_ready = 1;
        cyc();
        chk("p1_ins", 32'(bus.ins), 32'hA5A5);
        chk("p1_valid", 32'(bus.ins_valid), 32'd1);
        chk("p1_pc", 32'(bus.pc), 32'd1);
        chk("p1_cmd_none", 32'(bus.mem_cmd), 32'd0);

        // Plan 2: sequential fetch, one instruction per two cycles.
        for (int i = 1; i <= 3; i++) begin
            bus.ins_ack = 1;
            cyc();
            chk("p2_addr", 32'(bus.mem_addr), 32'(i));
            chk("p2_gap", 32'(bus.ins_valid), 32'd0);
            cyc();
            chk("p2_valid", 32'(bus.ins_valid), 32'd1);
        end
        bus.ins_ack = 0;

        // Plan 4: store with a concurrent ack, then load back.
        bus.d_req     = 1;
        bus.d_we      = 1;
        bus.d_addr    = 9'h040;
        bus.d_wdata   = 16'h1234;
        bus.ins_ack   = 1;
        bus.mem_ready = 0;
        cyc();
        chk("p4_cmd", 32'(bus.mem_cmd), 32'd2);
        chk("p4_addr", 32'(bus.mem_addr), 32'h040);
        chk("p4_wd", 32'(bus.write_data), 32'h1234);
        bus.d_req     = 0;
        bus.ins_ack   = 0;
        bus.mem_ready = 1;
        cyc();
        chk("p4_done", 32'(bus.d_done), 32'd1);
        chk("p4_valid", 32'(bus.ins_valid), 32'd1);
        chk("p4_hold", 32'(bus.mem_cmd), 32'd0);
        cyc();
        chk("p4_done_once", 32'(bus.d_done), 32'd0);
        bus.d_req = 1;
        bus.d_we  = 0;
        cyc();
        chk("p4_ld_cmd", 32'(bus.mem_cmd), 32'd1);
        bus.d_req = 0;
        cyc();
        chk("p4_rdata", 32'(bus.d_rdata), 32'h1234);

        // Plan 5: absolute branch.
        bus.ins_ack       = 1;
        bus.branch_en     = 1;
        bus.branch_target = 9'h100;
        cyc();
        chk("p5_addr", 32'(bus.mem_addr), 32'h100);
        bus.ins_ack   = 0;
        bus.branch_en = 0;
        cyc();
        chk("p5_pc", 32'(bus.pc), 32'h101);

        // Plan 3: wrap on fetch from 511, relative branch wrap.
        bus.ins_ack       = 1;
        bus.branch_en     = 1;
        bus.branch_target = 9'h1FF;
        cyc();
        chk("p3_addr", 32'(bus.mem_addr), 32'h1FF);
        bus.ins_ack   = 0;
        bus.branch_en = 0;
        cyc();
        chk("p3_wrap", 32'(bus.pc), 32'd0);
        bus.ins_ack       = 1;
        bus.branch_en     = 1;
        bus.branch_target = 9'h004;
        cyc();
        bus.ins_ack   = 0;
        bus.branch_en = 0;
        cyc();
        chk("p3_pc5", 32'(bus.pc), 32'd5);
        bus.ins_ack       = 1;
        bus.branch_en     = 1;
        bus.branch_rel    = 1;
        bus.branch_target = 9'h1FF;
        cyc();
        chk("p3_rel", 32'(bus.mem_addr), 32'd4);
        bus.ins_ack    = 0;
        bus.branch_en  = 0;
        bus.branch_rel = 0;
        cyc();

        // Plan 6: halt wins over branch; only reset leaves it.
        bus.ins_ack       = 1;
        bus.halt          = 1;
        bus.branch_en     = 1;
        bus.branch_target = 9'h055;
        cyc();
        chk("p6_halted", 32'(bus.halted), 32'd1);
        bus.halt      = 0;
        bus.branch_en = 0;
        repeat (4) cyc();
        chk("p6_stay", 32'(bus.halted), 32'd1);
        chk("p6_cmd", 32'(bus.mem_cmd), 32'd0);
        bus.ins_ack = 0;
        reset = 1;
        cyc();
        reset = 0;
        cyc();
        cyc();
        bus.ins_ack   = 1;
        bus.mem_ready = 0;
        cyc();
        chk("p6_fetch", 32'(bus.mem_cmd), 32'd1);
        chk("p6_fetch_pc", 32'(bus.pc), 32'd1);
        bus.ins_ack = 0;
        #1 reset = 1;
        #1;
        chk("p6_abort", 32'(bus.mem_cmd), 32'd0);
        chk("p6_pc", 32'(bus.pc), 32'd0);
        chk("p6_wd", 32'(bus.write_data), 32'd0);
        chk("p6_rd", 32'(bus.d_rdata), 32'd0);
        cyc();
        reset = 0;

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0 ||
                (m_stopped && $urandom_range(0, 9) == 0))
                reset = 1;
            else
                reset = 0;
            bus.mem_ready     = ($urandom_range(0, 2) != 0);
            bus.ins_ack       = ($urandom_range(0, 1) == 1);
            bus.branch_en     = ($urandom_range(0, 3) == 0);
            bus.branch_rel    = ($urandom_range(0, 1) == 1);
            bus.branch_target = AW'($urandom);
            bus.halt          = ($urandom_range(0, 99) == 0);
            bus.d_req         = ($urandom_range(0, 3) == 0);
            bus.d_we          = ($urandom_range(0, 1) == 1);
            bus.d_addr        = AW'($urandom);
            bus.d_wdata       = DW'($urandom);
            cyc();
        end
        reset = 0;
        idle_inputs();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
